// File: rtl/lm96570_cfg_sequencer.sv
// Register-write sequencer for the LM96570 SPI transceiver: issues a run of table entries on GO.
// Optional read-back verification of the SDO echo is enabled by defining LM96570_READBACK_EN.
module lm96570_cfg_sequencer #(
    parameter int DATA_WIDTH      = 70,
    parameter int BIT_COUNT_WIDTH = 8,
    parameter int ADDR_WIDTH      = 3,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int TX_PULSE_CYCLES = 4
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       CFG_WR,
    input  logic [ADDR_WIDTH-1:0]      CFG_ADDR,
    input  logic [DATA_WIDTH-1:0]      CFG_DATA,
    input  logic [BIT_COUNT_WIDTH-1:0] CFG_NBITS,
    input  logic                       GO,
    input  logic [ADDR_WIDTH-1:0]      FIRST,
    input  logic [ADDR_WIDTH:0]        COUNT,
    input  logic                       FIRE,
    output logic                       BUSY,
    output logic                       SEQ_DONE,
    output logic [1:0]                 ERR,
    output logic [ADDR_WIDTH-1:0]      ERR_IDX,
    output logic                       TX_EN,
    output logic                       SPI_START,
    output logic [DATA_WIDTH-1:0]      SPI_DATA_IN,
    output logic [BIT_COUNT_WIDTH-1:0] SPI_NUM_OF_BIT,
    input  logic                       SPI_DONE,
    input  logic [DATA_WIDTH-1:0]      SPI_RD_DATA
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TXP_W = $clog2(TX_PULSE_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TXP_W-1:0] TXP_LOAD = TXP_W'(TX_PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_DONE,
        S_CHECK,
        S_NEXT,
        S_FIRE,
        S_FINISH
    } state_t;

    state_t                      state_reg;
    logic [ADDR_WIDTH-1:0]       idx_reg;
    logic [ADDR_WIDTH:0]         remain_reg;
    logic                        fire_reg;
    logic [TMO_W-1:0]            tmo_reg;
    logic [TXP_W-1:0]            txp_reg;
    logic                        busy_reg;
    logic                        seq_done_reg;
    logic [1:0]                  err_reg;
    logic [ADDR_WIDTH-1:0]       err_idx_reg;
    logic                        tx_en_reg;
    logic                        spi_start_reg;
    logic [DATA_WIDTH-1:0]       spi_data_reg;
    logic [BIT_COUNT_WIDTH-1:0]  spi_nbits_reg;

    logic [DATA_WIDTH-1:0]       tab_data_reg  [DEPTH];
    logic [BIT_COUNT_WIDTH-1:0]  tab_nbits_reg [DEPTH];
    logic                        tab_wr;

    // Table is only writable while idle so an in-flight load never sees a torn entry.
    assign tab_wr = CFG_WR && (state_reg == S_IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_data_reg[i]  <= '0;
                tab_nbits_reg[i] <= '0;
            end
        end else if (tab_wr) begin
            tab_data_reg[CFG_ADDR]  <= CFG_DATA;
            tab_nbits_reg[CFG_ADDR] <= CFG_NBITS;
        end
    end

`ifdef LM96570_READBACK_EN
    logic [DATA_WIDTH-1:0] rb_mask;
    logic                  rb_mismatch;

    // Only the low n bits were shifted out, so only those are echoed back.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rb_mask
            assign rb_mask[gi] = (int'(spi_nbits_reg) > gi);
        end
    endgenerate

    assign rb_mismatch = |((SPI_RD_DATA ^ spi_data_reg) & rb_mask);
`else
    logic rd_data_unused;
    assign rd_data_unused = ^SPI_RD_DATA;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            remain_reg    <= '0;
            fire_reg      <= 1'b0;
            tmo_reg       <= '0;
            txp_reg       <= '0;
            busy_reg      <= 1'b0;
            seq_done_reg  <= 1'b0;
            err_reg       <= 2'b00;
            err_idx_reg   <= '0;
            tx_en_reg     <= 1'b0;
            spi_start_reg <= 1'b0;
            spi_data_reg  <= '0;
            spi_nbits_reg <= '0;
        end else begin
            seq_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (GO) begin
                        idx_reg     <= FIRST;
                        remain_reg  <= COUNT;
                        fire_reg    <= FIRE;
                        err_reg     <= 2'b00;
                        err_idx_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= (COUNT == '0) ? S_FINISH : S_LOAD;
                    end
                end
                S_LOAD: begin
                    spi_data_reg  <= tab_data_reg[idx_reg];
                    spi_nbits_reg <= tab_nbits_reg[idx_reg];
                    tmo_reg       <= TMO_LOAD;
                    state_reg     <= S_ISSUE;
                end
                S_ISSUE: begin
                    // DONE from the previous word is level-held; wait for it to fall.
                    if (spi_start_reg && !SPI_DONE) begin
                        spi_start_reg <= 1'b0;
                        tmo_reg       <= TMO_LOAD;
                        state_reg     <= S_WAIT_DONE;
                    end else if (tmo_reg == '0) begin
                        spi_start_reg <= 1'b0;
                        err_reg       <= 2'b01;
                        err_idx_reg   <= idx_reg;
                        state_reg     <= S_FINISH;
                    end else begin
                        spi_start_reg <= 1'b1;
                        tmo_reg       <= tmo_reg - 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (SPI_DONE) begin
                        state_reg <= S_CHECK;
                    end else if (tmo_reg == '0) begin
                        err_reg     <= 2'b01;
                        err_idx_reg <= idx_reg;
                        state_reg   <= S_FINISH;
                    end else begin
                        tmo_reg <= tmo_reg - 1'b1;
                    end
                end
                S_CHECK: begin
`ifdef LM96570_READBACK_EN
                    if (rb_mismatch) begin
                        err_reg     <= 2'b10;
                        err_idx_reg <= idx_reg;
                        state_reg   <= S_FINISH;
                    end else
`endif
                    state_reg <= S_NEXT;
                end
                S_NEXT: begin
                    idx_reg    <= idx_reg + 1'b1;
                    remain_reg <= remain_reg - 1'b1;
                    if (remain_reg == (ADDR_WIDTH + 1)'(1)) begin
                        if (fire_reg) begin
                            tx_en_reg <= 1'b1;
                            txp_reg   <= TXP_LOAD;
                            state_reg <= S_FIRE;
                        end else begin
                            state_reg <= S_FINISH;
                        end
                    end else begin
                        state_reg <= S_LOAD;
                    end
                end
                S_FIRE: begin
                    if (txp_reg == '0) begin
                        tx_en_reg <= 1'b0;
                        state_reg <= S_FINISH;
                    end else begin
                        txp_reg <= txp_reg - 1'b1;
                    end
                end
                S_FINISH: begin
                    seq_done_reg <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign BUSY           = busy_reg;
    assign SEQ_DONE       = seq_done_reg;
    assign ERR            = err_reg;
    assign ERR_IDX        = err_idx_reg;
    assign TX_EN          = tx_en_reg;
    assign SPI_START      = spi_start_reg;
    assign SPI_DATA_IN    = spi_data_reg;
    assign SPI_NUM_OF_BIT = spi_nbits_reg;

endmodule

// File: tb/tb_lm96570_cfg_sequencer.sv
// Bench for lm96570_cfg_sequencer: transceiver model plus table/sequence reference model.
module tb_lm96570_cfg_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CFG_WR = 1'b0;
    logic [2:0]  CFG_ADDR = '0;
    logic [69:0] CFG_DATA = '0;
    logic [7:0]  CFG_NBITS = '0;
    logic        GO = 1'b0;
    logic [2:0]  FIRST = '0;
    logic [3:0]  COUNT = '0;
    logic        FIRE = 1'b0;
    logic        BUSY, SEQ_DONE, TX_EN, SPI_START;
    logic [1:0]  ERR;
    logic [2:0]  ERR_IDX;
    logic [69:0] SPI_DATA_IN;
    logic [7:0]  SPI_NUM_OF_BIT;
    logic        SPI_DONE = 1'b0;
    logic [69:0] SPI_RD_DATA = '0;

    lm96570_cfg_sequencer dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .CFG_WR(CFG_WR), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .CFG_NBITS(CFG_NBITS),
        .GO(GO), .FIRST(FIRST), .COUNT(COUNT), .FIRE(FIRE),
        .BUSY(BUSY), .SEQ_DONE(SEQ_DONE), .ERR(ERR), .ERR_IDX(ERR_IDX), .TX_EN(TX_EN),
        .SPI_START(SPI_START), .SPI_DATA_IN(SPI_DATA_IN), .SPI_NUM_OF_BIT(SPI_NUM_OF_BIT),
        .SPI_DONE(SPI_DONE), .SPI_RD_DATA(SPI_RD_DATA)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [69:0] ref_data  [8];
    logic [7:0]  ref_nbits [8];

    // Transceiver model state and observation queues.
    logic [69:0] q_data  [$];
    logic [7:0]  q_nbits [$];
    logic        prev_start = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_hang = 1'b0;
    int          m_cnt = 0;
    int          m_txn = 0;
    int          m_corrupt_n = 0;
    logic [69:0] m_echo = '0;
    int          tx_cnt = 0;
    int          sd_cnt = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    always @(negedge CLK) begin
        if (!RESET_N) begin
            m_busy     = 1'b0;
            SPI_DONE   = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (SPI_START && !prev_start) begin
                SPI_DONE = 1'b0;
                q_data.push_back(SPI_DATA_IN);
                q_nbits.push_back(SPI_NUM_OF_BIT);
                m_txn++;
                m_echo = SPI_DATA_IN;
                if (m_txn == m_corrupt_n) m_echo[3] = ~m_echo[3];
                m_busy = !m_hang;
                m_cnt  = $urandom_range(2, 6);
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    SPI_DONE    = 1'b1;
                    SPI_RD_DATA = m_echo;
                    m_busy      = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            prev_start = SPI_START;
        end
        if (TX_EN) tx_cnt++;
        if (SEQ_DONE) sd_cnt++;
    end

    task automatic write_entry(input int addr, input logic [69:0] data, input int nbits);
        @(negedge CLK);
        CFG_WR = 1'b1; CFG_ADDR = 3'(addr); CFG_DATA = data; CFG_NBITS = 8'(nbits);
        @(negedge CLK);
        CFG_WR = 1'b0;
        ref_data[addr]  = data;
        ref_nbits[addr] = 8'(nbits);
    endtask

    function automatic logic [69:0] rand70();
        return {6'($urandom), $urandom, $urandom};
    endfunction

    // Runs one GO and compares the observed transactions/flags against the reference table.
    task automatic run_seq(input string tag, input int first, input int count, input bit fire,
                           input bit poke, input bit wr_go,
                           input logic [1:0] exp_err, input int exp_eidx, input int exp_issued);
        int  cyc;
        bit  done;
        int  exp_tx;
        int  n;
        q_data.delete(); q_nbits.delete();
        tx_cnt = 0; sd_cnt = 0; m_txn = 0;
        @(negedge CLK);
        GO = 1'b1; FIRST = 3'(first); COUNT = 4'(count); FIRE = fire;
        if (wr_go) begin
            CFG_WR = 1'b1; CFG_ADDR = 3'(first); CFG_DATA = rand70(); CFG_NBITS = 8'($urandom_range(1, 70));
            ref_data[first] = CFG_DATA; ref_nbits[first] = CFG_NBITS;
        end
        @(negedge CLK);
        GO = 1'b0; CFG_WR = 1'b0;
        check({tag, "/busy_after_go"}, 128'(BUSY), 128'(1));
        cyc = 1; done = 0;
        while (!done && cyc < 3000) begin
            if (SEQ_DONE) begin
                done = 1;
            end else begin
                if (poke && cyc == 6) begin
                    CFG_WR = 1'b1; CFG_ADDR = 3'((first + 1) % 8); CFG_DATA = ~ref_data[(first + 1) % 8];
                    CFG_NBITS = 8'd33; GO = 1'b1; FIRST = 3'(first + 3); COUNT = 4'd1;
                end
                if (poke && cyc == 7) begin
                    CFG_WR = 1'b0; GO = 1'b0;
                end
                @(negedge CLK);
                cyc++;
            end
        end
        check({tag, "/seq_done_seen"}, 128'(done), 128'(1));
        if (count == 0) check({tag, "/done_latency"}, 128'(cyc), 128'(2));
        if (exp_err == 2'b01) check({tag, "/timeout_len"}, 128'(cyc >= 1024), 128'(1));
        repeat (6) @(negedge CLK);
        exp_tx = (exp_err == 2'b00 && count > 0 && fire) ? 4 : 0;
        check({tag, "/busy_end"}, 128'(BUSY), 128'(0));
        check({tag, "/seq_done_pulses"}, 128'(sd_cnt), 128'(1));
        check({tag, "/tx_en_cycles"}, 128'(tx_cnt), 128'(exp_tx));
        check({tag, "/err"}, 128'(ERR), 128'(exp_err));
        if (exp_err != 2'b00) check({tag, "/err_idx"}, 128'(ERR_IDX), 128'(exp_eidx));
        check({tag, "/issued_count"}, 128'(q_data.size()), 128'(exp_issued));
        n = (q_data.size() < exp_issued) ? q_data.size() : exp_issued;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s/data%0d", tag, k), 128'(q_data[k]), 128'(ref_data[(first + k) % 8]));
            check($sformatf("%s/nbits%0d", tag, k), 128'(q_nbits[k]), 128'(ref_nbits[(first + k) % 8]));
        end
        $display("seq %s first=%0d count=%0d fire=%0d issued=%0d err=%0d tx=%0d", tag, first, count,
                 fire, q_data.size(), ERR, tx_cnt);
    endtask

    initial begin
        int first, count;
        bit fire;
        for (int i = 0; i < 8; i++) begin
            ref_data[i] = '0; ref_nbits[i] = '0;
        end
        #1;
        check("reset/busy", 128'(BUSY), 128'(0));
        check("reset/spi_start", 128'(SPI_START), 128'(0));
        check("reset/err", 128'(ERR), 128'(0));
        check("reset/spi_data", 128'(SPI_DATA_IN), 128'(0));
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        write_entry(0, 70'hA5A5A5, 24);
        write_entry(1, 70'h123456, 24);
        write_entry(2, 70'hFFFFFF, 24);
        run_seq("basic", 0, 3, 1'b1, 1'b0, 1'b0, 2'b00, 0, 3);

        write_entry(6, rand70(), 70);
        write_entry(7, rand70(), 17);
        run_seq("wrap", 6, 4, 1'b0, 1'b1, 1'b0, 2'b00, 0, 4);

        run_seq("count0", 3, 0, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0);

        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 3; w++)
                write_entry($urandom_range(0, 7), rand70(), $urandom_range(1, 70));
            first = $urandom_range(0, 7);
            count = $urandom_range(0, 8);
            fire  = 1'($urandom);
            run_seq($sformatf("rand%0d", it), first, count, fire,
                    (it % 2 == 1) && (count >= 3), (it % 3 == 0), 2'b00, 0, count);
        end

        m_hang = 1'b1;
        run_seq("timeout", 2, 3, 1'b1, 1'b0, 1'b0, 2'b01, 2, 1);
        m_hang = 1'b0;

`ifdef LM96570_READBACK_EN
        write_entry(0, 70'hA5A5A5, 24);
        write_entry(1, 70'h123456, 24);
        write_entry(2, 70'hFFFFFF, 24);
        m_corrupt_n = 2;
        run_seq("readback", 0, 3, 1'b1, 1'b1, 1'b0, 2'b10, 1, 2);
        m_corrupt_n = 0;
`endif

        // Reset while a transaction is being issued.
        write_entry(5, rand70(), 40);
        @(negedge CLK);
        GO = 1'b1; FIRST = 3'd5; COUNT = 4'd2; FIRE = 1'b1;
        @(negedge CLK);
        GO = 1'b0;
        for (int c = 0; c < 20 && !SPI_START; c++) @(negedge CLK);
        check("midreset/start_seen", 128'(SPI_START), 128'(1));
        RESET_N = 1'b0;
        #1;
        check("midreset/spi_start", 128'(SPI_START), 128'(0));
        check("midreset/busy", 128'(BUSY), 128'(0));
        check("midreset/tx_en", 128'(TX_EN), 128'(0));
        check("midreset/seq_done", 128'(SEQ_DONE), 128'(0));
        check("midreset/err", 128'(ERR), 128'(0));
        for (int i = 0; i < 8; i++) begin
            ref_data[i] = '0; ref_nbits[i] = '0;
        end
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        run_seq("post_reset", 5, 2, 1'b1, 1'b0, 1'b0, 2'b00, 0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
